ibex_mem_responder: RTL and testbench

//  Memory-side responder for the core's instruction/data bus (req/gnt/rvalid with 7-bit integrity).

---
 rtl/ibex_mem_resp_pkg.sv | 13 +
 rtl/ibex_mem_resp_chk.sv | 19 +
 rtl/ibex_mem_resp_pipe.sv | 31 +++
 rtl/prim_secded_inv_39_32_enc.sv | 24 ++
 rtl/ibex_mem_responder.sv | 133 +++++++++++++
 tb/tb_ibex_mem_responder.sv | 248 ++++++++++++++++++++++++
 6 files changed

// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and constants for the memory-side bus responder.
package ibex_mem_resp_pkg;

    localparam int unsigned MaxRespLatency = 8;
    localparam int unsigned IntgWidth      = 7;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } resp_entry_t;

endpackage

// File: rtl/ibex_mem_resp_chk.sv
// Invariants of the responder's outstanding-request counter.
module ibex_mem_resp_chk #(
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned CntW           = 2
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            gnt_i,
    input logic            rvalid_i,
    input logic [CntW-1:0] cnt_i
);

    cnt_no_overflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_i <= CntW'(MaxOutstanding));

    cnt_no_underflow_a: assert property (@(posedge clk_i) disable iff (rst_i)
        !((cnt_i == CntW'(0)) && rvalid_i && !gnt_i));

endmodule

// File: rtl/ibex_mem_resp_pipe.sv
// Fixed-depth response delay line; a flush empties every stage.
module ibex_mem_resp_pipe
    import ibex_mem_resp_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic        clk_i,
    input  logic        flush_i,
    input  resp_entry_t in_i,
    output resp_entry_t out_o
);

    resp_entry_t stage_r [Depth];

    // Shift responses one stage per cycle, dropping everything on flush.
    always_ff @(posedge clk_i) begin
        if (flush_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= in_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign out_o = stage_r[Depth-1];

endmodule

// File: rtl/prim_secded_inv_39_32_enc.sv
// Inverted Hsiao SECDED(39,32) encoder: data in the low 32 bits, check bits in [38:32].
module prim_secded_inv_39_32_enc (
    input  logic [31:0] data_i,
    output logic [38:0] data_o
);

    logic [38:0] raw_s;

    // Each check bit is the parity of a fixed subset of data bits.
    always_comb begin
        raw_s     = {7'h00, data_i};
        raw_s[32] = ^(raw_s & 39'h00_2606_BD25);
        raw_s[33] = ^(raw_s & 39'h00_DEBA_8050);
        raw_s[34] = ^(raw_s & 39'h00_413D_89AA);
        raw_s[35] = ^(raw_s & 39'h00_3123_4ED1);
        raw_s[36] = ^(raw_s & 39'h00_C2C1_323B);
        raw_s[37] = ^(raw_s & 39'h00_2DCC_624C);
        raw_s[38] = ^(raw_s & 39'h00_9850_5586);
    end

    // Inversion keeps an all-zero word from producing all-zero check bits.
    assign data_o = raw_s ^ 39'h2A_0000_0000;

endmodule

// File: rtl/ibex_mem_responder.sv
// Memory-side req/gnt/rvalid responder over a flop-array memory with bus integrity.
module ibex_mem_responder
    import ibex_mem_resp_pkg::*;
#(
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          CheckWIntg     = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 req_i,
    output logic                 gnt_o,
    input  logic                 we_i,
    input  logic [3:0]           be_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [IntgWidth-1:0] wdata_intg_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic [IntgWidth-1:0] rdata_intg_o,
    output logic                 err_o,
    output logic                 intg_err_o
);

    localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [31:0]     mem_r [MemWords];
    logic [CntW-1:0] outstanding_r;
    logic            intg_err_r;

    logic [38:0]     wdata_enc_s;
    logic [38:0]     rdata_enc_s;
    logic            gnt_s;
    logic            range_err_s;
    logic            intg_err_s;
    logic            wr_en_s;
    logic [IdxW-1:0] idx_s;
    resp_entry_t     resp_in_s;
    resp_entry_t     resp_out_s;
    logic            unused_s;

    prim_secded_inv_39_32_enc u_wdata_enc (
        .data_i (wdata_i),
        .data_o (wdata_enc_s)
    );

    prim_secded_inv_39_32_enc u_rdata_enc (
        .data_i (resp_out_s.rdata),
        .data_o (rdata_enc_s)
    );

    assign gnt_s       = req_i & ~stall_i & ~rst_i & (outstanding_r < CntW'(MaxOutstanding));
    assign range_err_s = (addr_i[31:2] >= 30'(MemWords));
    assign intg_err_s  = CheckWIntg & we_i & (wdata_intg_i != wdata_enc_s[38:32]);
    assign idx_s       = addr_i[IdxW+1:2];
    assign wr_en_s     = gnt_s & we_i & ~range_err_s & ~intg_err_s;

    // Build the response for this cycle's grant; reads see all earlier writes.
    always_comb begin
        resp_in_s = '0;
        if (gnt_s) begin
            resp_in_s.valid = 1'b1;
            resp_in_s.err   = range_err_s | intg_err_s;
            if (!(range_err_s | intg_err_s) && !we_i) begin
                resp_in_s.rdata = mem_r[idx_s];
            end else begin
                resp_in_s.rdata = 32'h0000_0000;
            end
        end else begin
            resp_in_s = '0;
        end
    end

    // Byte-masked memory update at the end of the grant cycle; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Outstanding-request accounting and the one-cycle integrity alarm.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            outstanding_r <= '0;
            intg_err_r    <= 1'b0;
        end else begin
            intg_err_r <= gnt_s & intg_err_s;
            case ({gnt_s, resp_out_s.valid})
                2'b10:   outstanding_r <= outstanding_r + CntW'(1);
                2'b01:   outstanding_r <= outstanding_r - CntW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    ibex_mem_resp_pipe #(
        .Depth (RespLatency)
    ) u_pipe (
        .clk_i   (clk_i),
        .flush_i (rst_i),
        .in_i    (resp_in_s),
        .out_o   (resp_out_s)
    );

    ibex_mem_resp_chk #(
        .MaxOutstanding (MaxOutstanding),
        .CntW           (CntW)
    ) u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .gnt_i    (gnt_s),
        .rvalid_i (resp_out_s.valid),
        .cnt_i    (outstanding_r)
    );

    assign gnt_o        = gnt_s;
    assign rvalid_o     = resp_out_s.valid;
    assign err_o        = resp_out_s.err;
    assign rdata_o      = resp_out_s.rdata;
    assign rdata_intg_o = rdata_enc_s[38:32];
    assign intg_err_o   = intg_err_r;

    // Data halves of the encoder outputs and the byte offset are not needed.
    assign unused_s = ^{wdata_enc_s[31:0], rdata_enc_s[31:0], addr_i[1:0]};

endmodule

// File: tb/tb_ibex_mem_responder.sv
// Randomized and directed bench for ibex_mem_responder against a transaction-level model.
module tb_ibex_mem_responder;

    localparam int LAT = 3;
    localparam int MO  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        req_i = 1'b0;
    logic        gnt_o;
    logic        we_i = 1'b0;
    logic [3:0]  be_i = 4'h0;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic [6:0]  wdata_intg_i = 7'h0;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [6:0]  rdata_intg_o;
    logic        err_o;
    logic        intg_err_o;

    ibex_mem_responder #(
        .MemWords       (1024),
        .RespLatency    (LAT),
        .MaxOutstanding (MO),
        .CheckWIntg     (1'b1)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .stall_i      (stall_i),
        .req_i        (req_i),
        .gnt_o        (gnt_o),
        .we_i         (we_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .wdata_intg_i (wdata_intg_i),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .rdata_intg_o (rdata_intg_o),
        .err_o        (err_o),
        .intg_err_o   (intg_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [6:0]  intg;
    } txn_t;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    txn_t        txq[$];
    exp_t        rq[$];
    logic [31:0] mem_m [int];
    bit          intg_pend = 1'b0;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference inverted SECDED(39,32) check-bit generator.
    function automatic logic [6:0] enc(input logic [31:0] d);
        logic [31:0] masks [7];
        logic [6:0]  c;
        masks[0] = 32'h2606_BD25; masks[1] = 32'hDEBA_8050; masks[2] = 32'h413D_89AA;
        masks[3] = 32'h3123_4ED1; masks[4] = 32'hC2C1_323B; masks[5] = 32'h2DCC_624C;
        masks[6] = 32'h9850_5586;
        for (int i = 0; i < 7; i++) c[i] = ^(d & masks[i]);
        return c ^ 7'h2A;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus cycle of the model: grant decision, response ordering, memory semantics.
    task automatic model_cycle();
        bit   gexp;
        bit   next_pend;
        exp_t e;
        int   word;
        logic [31:0] old;
        gexp = req_i && !stall_i && !rst_i && (rq.size() < MO);
        check_val("gnt", 32'(gnt_o), 32'(gexp));
        check_val("intg_err", 32'(intg_err_o), 32'(intg_pend));
        next_pend = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            check_val("rvalid", 32'(rvalid_o), 32'd1);
            check_val("err", 32'(err_o), 32'(rq[0].err));
            check_val("rdata", rdata_o, rq[0].rdata);
            check_val("rdata_intg", 32'(rdata_intg_o), 32'(enc(rq[0].rdata)));
            void'(rq.pop_front());
        end else begin
            check_val("rvalid", 32'(rvalid_o), 32'd0);
        end
        if (gexp) begin
            word    = int'(addr_i[31:2]);
            e.due   = cyc + LAT;
            e.rdata = 32'h0;
            e.err   = (addr_i[31:2] >= 30'd1024) || (we_i && (wdata_intg_i != enc(wdata_i)));
            next_pend = we_i && (wdata_intg_i != enc(wdata_i));
            if (!e.err) begin
                if (we_i) begin
                    old = mem_m.exists(word) ? mem_m[word] : 32'h0;
                    for (int b = 0; b < 4; b++) if (be_i[b]) old[8*b +: 8] = wdata_i[8*b +: 8];
                    mem_m[word] = old;
                end else begin
                    e.rdata = mem_m[word];
                end
            end
            rq.push_back(e);
            void'(txq.pop_front());
        end
        if (rst_i) rq.delete();
        intg_pend = next_pend;
        cyc++;
    endtask

    task automatic step(input bit rst, input bit stall);
        @(posedge clk_i);
        #1;
        rst_i   = rst;
        stall_i = stall;
        if (txq.size() > 0) begin
            req_i = 1'b1; we_i = txq[0].we; be_i = txq[0].be;
            addr_i = txq[0].addr; wdata_i = txq[0].wdata; wdata_intg_i = txq[0].intg;
        end else begin
            req_i = 1'b0; we_i = 1'($urandom); be_i = 4'($urandom);
            addr_i = $urandom; wdata_i = $urandom; wdata_intg_i = 7'($urandom);
        end
        @(negedge clk_i);
        model_cycle();
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                           input logic [6:0] flip);
        txn_t t;
        t.we = 1'b1; t.be = be; t.addr = a; t.wdata = d; t.intg = enc(d) ^ flip;
        txq.push_back(t);
    endtask

    task automatic push_rd(input logic [31:0] a);
        txn_t t;
        t.we = 1'b0; t.be = 4'($urandom); t.addr = a; t.wdata = $urandom; t.intg = 7'($urandom);
        txq.push_back(t);
    endtask

    task automatic drain();
        int n = 0;
        while ((txq.size() > 0 || rq.size() > 0) && n < 200) begin
            step(1'b0, 1'b0);
            n++;
        end
        check_val("drain", 32'(txq.size() + rq.size()), 32'd0);
    endtask

    function automatic logic [31:0] pool_addr(input int k);
        int w;
        w = (k == 15) ? 1023 : k;
        return 32'(w) << 2;
    endfunction

    initial begin
        int n;
        txn_t t;
        repeat (2) @(posedge clk_i);
        step(1'b0, 1'b0);
        check_val("rst_rvalid", 32'(rvalid_o), 32'd0);
        check_val("rst_err", 32'(err_o), 32'd0);
        check_val("rst_rdata", rdata_o, 32'h0);
        check_val("rst_rintg", 32'(rdata_intg_o), 32'(enc(32'h0)));
        check_val("rst_intg_err", 32'(intg_err_o), 32'd0);

        for (int k = 0; k < 16; k++) push_wr(pool_addr(k), $urandom, 4'hF, 7'h00);
        drain();

        // Full write then read back.
        push_wr(32'h10, 32'hDEAD_BEEF, 4'hF, 7'h00);
        push_rd(32'h10);
        drain();
        // Partial byte-lane merge.
        push_wr(32'h14, 32'h1122_3344, 4'hF, 7'h00);
        push_wr(32'h14, 32'hAABB_CCDD, 4'h5, 7'h00);
        push_rd(32'h14);
        drain();
        // Out-of-range read and write must not alias onto word 0.
        push_rd(32'h0000_1000);
        push_wr(32'h0000_1000, 32'h5A5A_5A5A, 4'hF, 7'h00);
        push_rd(32'h0);
        push_rd(pool_addr(15));
        drain();
        // Bad write integrity leaves memory untouched; be=0 write gets a clean response.
        push_wr(32'h18, 32'hCAFE_F00D, 4'hF, 7'h01);
        push_rd(32'h18);
        push_wr(32'h18, 32'h0BAD_0BAD, 4'h0, 7'h00);
        push_rd(32'h18);
        drain();
        // Back-to-back reads under a held request.
        for (int k = 0; k < 4; k++) push_rd(pool_addr(k));
        drain();
        // Reset while two reads are in flight drops both responses.
        push_rd(pool_addr(1));
        push_rd(pool_addr(2));
        n = 0;
        while (txq.size() > 0 && n < 20) begin
            step(1'b0, 1'b0);
            n++;
        end
        check_val("t6_granted", 32'(rq.size()), 32'd2);
        step(1'b1, 1'b0);
        push_rd(pool_addr(3));
        step(1'b0, 1'b0);
        drain();

        // Randomized traffic with stalls and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (txq.size() < 2 && $urandom_range(0, 3) != 0) begin
                t.we    = 1'($urandom);
                t.be    = 4'($urandom);
                t.wdata = $urandom;
                if ($urandom_range(0, 9) == 0) t.addr = $urandom | 32'h0000_1000;
                else t.addr = pool_addr($urandom_range(0, 15)) | 32'($urandom_range(0, 3));
                t.intg  = enc(t.wdata);
                if ($urandom_range(0, 6) == 0) t.intg = t.intg ^ (7'h01 << $urandom_range(0, 6));
                txq.push_back(t);
            end
            step($urandom_range(0, 79) == 0, $urandom_range(0, 4) == 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
